// File: rtl/riscv_lsu_pkg.sv
// Shared load/store definitions: funct3 encodings, sequencer states and the
// funct3-to-beat-count mapping.
package riscv_lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        BEAT,
        RESP
    } state_t;

    // Number of byte beats for an access size; 0 flags the reserved size 11.
    function automatic logic [2:0] size_from_funct3(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            2'b10:   return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Sign/zero extension of an assembled little-endian load word by funct3.
// Purely combinational so the core's forwarding path can share it.
module lsu_load_ext
    import riscv_lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [31:0] raw,
    output logic [31:0] ext
);

    always_comb begin
        case (funct3)
            F3_B:    ext = {{24{raw[7]}}, raw[7:0]};
            F3_H:    ext = {{16{raw[15]}}, raw[15:0]};
            F3_BU:   ext = {24'h0, raw[7:0]};
            F3_HU:   ext = {16'h0, raw[15:0]};
            default: ext = raw;
        endcase
    end

endmodule

// File: rtl/lsu_byte_seq.sv
// Load/store sequencer: splits one RV32I access into 1/2/4 little-endian byte
// beats on a byte-wide memory and returns one registered completion pulse.
module lsu_byte_seq
    import riscv_lsu_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    state_t            state;
    logic              write_q;
    logic [2:0]        funct3_q;
    logic [ADDR_W-1:0] base_q;
    logic [31:0]       wdata_q;
    logic [2:0]        beats_q;
    logic [1:0]        k;
    logic [31:0]       asm_q;

    logic [2:0]        req_beats;
    logic              req_illegal;
    logic [1:0]        k_next;
    logic              last_beat;
    logic [31:0]       asm_next;
    logic [31:0]       ext_data;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^req_addr[31:ADDR_W];

    assign req_beats = size_from_funct3(req_funct3);

    always_comb begin
        req_illegal = (req_beats == 3'd0)
                   || (req_write && req_funct3[2])
                   || ((req_funct3[1:0] == 2'b01) && req_addr[0])
                   || ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    end

    assign k_next    = k + 2'd1;
    assign last_beat = ({1'b0, k} == (beats_q - 3'd1));

    // Current read byte merged into its lane so the final beat can respond
    // in the same edge that captures it.
    always_comb begin
        asm_next = asm_q;
        if (!write_q) begin
            asm_next[{k, 3'b000} +: 8] = mem_rdata;
        end
    end

    lsu_load_ext u_load_ext (
        .funct3 (funct3_q),
        .raw    (asm_next),
        .ext    (ext_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= 8'h0;
            write_q    <= 1'b0;
            funct3_q   <= 3'h0;
            base_q     <= '0;
            wdata_q    <= 32'h0;
            beats_q    <= 3'h0;
            k          <= 2'h0;
            asm_q      <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        write_q   <= req_write;
                        funct3_q  <= req_funct3;
                        base_q    <= req_addr[ADDR_W-1:0];
                        wdata_q   <= req_wdata;
                        beats_q   <= req_beats;
                        k         <= 2'h0;
                        req_ready <= 1'b0;
                        if (req_illegal) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= 32'h0;
                        end else begin
                            // First beat's strobes are set up here so they are registered.
                            state     <= BEAT;
                            mem_read  <= !req_write;
                            mem_write <= req_write;
                            mem_addr  <= req_addr[ADDR_W-1:0];
                            mem_wdata <= req_wdata[7:0];
                        end
                    end
                end
                BEAT: begin
                    k     <= k_next;
                    asm_q <= asm_next;
                    if (last_beat) begin
                        state      <= RESP;
                        mem_read   <= 1'b0;
                        mem_write  <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= write_q ? 32'h0 : ext_data;
                    end else begin
                        mem_addr  <= base_q + ADDR_W'(k_next);
                        mem_wdata <= wdata_q[{k_next, 3'b000} +: 8];
                    end
                end
                RESP: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_byte_seq.sv
// Directed and randomized bench for lsu_byte_seq against a byte-array memory
// and an arithmetic reference model of load/store results and beat timing.
module tb_lsu_byte_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_read;
    logic        mem_write;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_init;

    logic [7:0]  tb_mem  [256];
    logic [7:0]  ref_mem [256];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    lsu_byte_seq #(.ADDR_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    function automatic logic [7:0] init_pat(input int i);
        return 8'((i * 37 + 11) & 255);
    endfunction

    assign mem_rdata = tb_mem[mem_addr];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) tb_mem[i] <= init_pat(i);
        end else if (mem_write) begin
            tb_mem[mem_addr] <= mem_wdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected outcome from the access rules: legality, beat count, load value.
    function automatic void model(input logic w, input logic [2:0] f3, input logic [31:0] a,
                                  output bit ill, output int n, output logic [31:0] rd);
        int     sz;
        int     lo;
        longint v;
        sz  = int'(f3[1:0]);
        lo  = int'(a[7:0]);
        ill = (sz == 3) || (w && f3[2]) || (sz == 1 && (lo % 2) != 0) || (sz == 2 && (lo % 4) != 0);
        n   = ill ? 0 : (1 << sz);
        rd  = 32'h0;
        if (!ill && !w) begin
            v = 0;
            for (int i = 0; i < n; i++) v += longint'(ref_mem[(lo + i) % 256]) << (8 * i);
            if (!f3[2] && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
            rd = 32'(v);
        end
    endfunction

    task automatic do_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input string tag, output logic [31:0] rd_seen);
        bit          ill;
        int          n;
        logic [31:0] exp_rd;
        int          lo;
        int          beats;
        int          bad;
        int          resp_cnt;
        int          resp_cyc;
        logic        err_seen;
        logic        ready_after;
        int          mem_bad;
        model(w, f3, a, ill, n, exp_rd);
        lo = int'(a[7:0]);
        chk({tag, " ready"}, 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_write  = w;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
        beats = 0; bad = 0; resp_cnt = 0; resp_cyc = -1;
        err_seen = 1'b0; ready_after = 1'b0; rd_seen = 32'h0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (mem_read && mem_write) bad++;
            if (mem_read || mem_write) begin
                if (c != beats + 1 || mem_write != w || mem_addr != 8'((lo + beats) % 256)
                    || (w && mem_wdata != 8'(wd >> (8 * beats)))) bad++;
                beats++;
            end
            if (resp_valid) begin
                resp_cnt++;
                if (resp_cyc < 0) begin
                    resp_cyc = c;
                    rd_seen  = resp_rdata;
                    err_seen = resp_err;
                end
            end
            if (resp_cyc > 0 && c == resp_cyc + 1) begin
                ready_after = req_ready;
                break;
            end
        end
        chk({tag, " beats"},     32'(beats), 32'(n));
        chk({tag, " strobes"},   32'(bad), 32'd0);
        chk({tag, " resp_cnt"},  32'(resp_cnt), 32'd1);
        chk({tag, " resp_cyc"},  32'(resp_cyc), ill ? 32'd1 : 32'(n + 1));
        chk({tag, " err"},       32'(err_seen), 32'(ill));
        chk({tag, " rdata"},     rd_seen, exp_rd);
        chk({tag, " ready_ret"}, 32'(ready_after), 32'd1);
        if (!ill && w) begin
            mem_bad = 0;
            for (int i = 0; i < n; i++) begin
                ref_mem[(lo + i) % 256] = 8'(wd >> (8 * i));
                if (tb_mem[(lo + i) % 256] !== ref_mem[(lo + i) % 256]) mem_bad++;
            end
            chk({tag, " mem"}, 32'(mem_bad), 32'd0);
        end
    endtask

    initial begin
        logic [31:0] rd;
        int          cnt;
        logic        rv5, rdy6, rv8, rv_rst;
        logic [31:0] rd8;
        logic        w;
        logic [2:0]  f3;
        logic [31:0] a;

        rst_n = 1'b1; mem_init = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'h0; req_addr = 32'h0; req_wdata = 32'h0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_pat(i);
        #2 rst_n = 1'b0;
        #1;
        chk("rst req_ready",  32'(req_ready), 32'd1);
        chk("rst resp_valid", 32'(resp_valid), 32'd0);
        chk("rst resp_rdata", resp_rdata, 32'h0);
        chk("rst resp_err",   32'(resp_err), 32'd0);
        chk("rst mem_strobe", {30'h0, mem_read, mem_write}, 32'h0);
        chk("rst mem_addr",   32'(mem_addr), 32'h0);
        chk("rst mem_wdata",  32'(mem_wdata), 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        mem_init = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);

        do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, "SW 10", rd);
        chk("SW 10 rdata0", rd, 32'h0);
        do_req(1'b0, 3'b010, 32'h10, 32'h0, "LW 10", rd);
        chk("LW 10 const", rd, 32'hDEADBEEF);
        do_req(1'b0, 3'b000, 32'h13, 32'h0, "LB 13", rd);
        chk("LB 13 const", rd, 32'hFFFFFFDE);
        do_req(1'b0, 3'b100, 32'h13, 32'h0, "LBU 13", rd);
        chk("LBU 13 const", rd, 32'h000000DE);
        do_req(1'b0, 3'b001, 32'h12, 32'h0, "LH 12", rd);
        chk("LH 12 const", rd, 32'hFFFFDEAD);
        do_req(1'b0, 3'b101, 32'h12, 32'h0, "LHU 12", rd);
        chk("LHU 12 const", rd, 32'h0000DEAD);
        do_req(1'b0, 3'b001, 32'h11, 32'h0, "LH 11 misaligned", rd);
        do_req(1'b1, 3'b010, 32'h12, 32'h55AA55AA, "SW 12 misaligned", rd);
        do_req(1'b0, 3'b011, 32'h10, 32'h0, "f3 011", rd);
        do_req(1'b1, 3'b100, 32'h10, 32'h0, "store f3 100", rd);

        // Held request during a busy store.
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h40; req_wdata = 32'h000000A5;
        @(posedge clk);
        #1;
        req_write = 1'b0; req_funct3 = 3'b000; req_addr = 32'h40;
        cnt = 0; rv5 = 1'b0; rdy6 = 1'b0; rv8 = 1'b0; rd8 = 32'h0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (resp_valid) cnt++;
            if (c == 5) rv5 = resp_valid;
            if (c == 6) rdy6 = req_ready;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int c = 7; c <= 9; c++) begin
            @(negedge clk);
            if (resp_valid) begin
                cnt++;
                if (c == 8) begin rv8 = 1'b1; rd8 = resp_rdata; end
            end
        end
        chk("held sw resp c5",   32'(rv5), 32'd1);
        chk("held ready c6",     32'(rdy6), 32'd1);
        chk("held lb resp c8",   32'(rv8), 32'd1);
        chk("held lb rdata",     rd8, 32'hFFFFFFA5);
        chk("held resp count",   32'(cnt), 32'd2);
        ref_mem[8'h40] = 8'hA5; ref_mem[8'h41] = 8'h00; ref_mem[8'h42] = 8'h00; ref_mem[8'h43] = 8'h00;

        // Reset during the third beat of a word store.
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h20; req_wdata = 32'h11223344;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst strobes", {30'h0, mem_read, mem_write}, 32'h0);
        chk("midrst ready",   32'(req_ready), 32'd1);
        rv_rst = resp_valid;
        repeat (2) begin
            @(negedge clk);
            rv_rst = rv_rst | resp_valid;
        end
        rst_n = 1'b1;
        @(negedge clk);
        rv_rst = rv_rst | resp_valid;
        chk("midrst no resp",  32'(rv_rst), 32'd0);
        chk("midrst ready up", 32'(req_ready), 32'd1);
        chk("midrst mem20",    32'(tb_mem[8'h20]), 32'h44);
        chk("midrst mem21",    32'(tb_mem[8'h21]), 32'h33);
        chk("midrst mem22",    32'(tb_mem[8'h22]), 32'(ref_mem[8'h22]));
        chk("midrst mem23",    32'(tb_mem[8'h23]), 32'(ref_mem[8'h23]));
        ref_mem[8'h20] = 8'h44; ref_mem[8'h21] = 8'h33;

        for (int i = 0; i < 40; i++) begin
            w  = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & 32'hFFFFFFFC;
            do_req(w, f3, a, $urandom, $sformatf("rnd%0d", i), rd);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lsu_byte_seq.md
# lsu_byte_seq

Load/store sequencer between the core's memory stage and the byte-wide data memory. It accepts one RV32I load or store per request and breaks it into 1, 2 or 4 single-byte accesses in little-endian order. For loads it assembles and sign- or zero-extends the result. For stores it drives one byte per cycle. It is the initiator for the data memory, which reads combinationally and writes synchronously.

## Interface
Parameters:
- ADDR_W, 8, width of the memory byte address; request addresses are truncated to this width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  core request strobe.
- req_ready  out  1  high when a request can be accepted.
- req_write  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3: LB 000, LH 001, LW 010, LBU 100, LHU 101, SB 000, SH 001, SW 010.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned access or illegal funct3, qualified by resp_valid.
- mem_read  out  1  memory read enable.
- mem_write  out  1  memory write enable.
- mem_addr  out  ADDR_W  byte address.
- mem_wdata  out  8  store byte.
- mem_rdata  in  8  read byte, combinational from mem_addr.

## Operation
- States: IDLE, BEAT, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid, latch write, funct3, addr[ADDR_W-1:0] and wdata.
  - Set beat count N from funct3[1:0]: 00→1, 01→2, 10→4.
  - Legal request: clear beat counter k and go to BEAT.
  - Illegal request goes straight to RESP with err=1 and no memory strobes. Illegal means:
    - funct3[1:0]=11;
    - a store with funct3[2]=1;
    - a halfword with addr[0]=1;
    - a word with addr[1:0]≠0.
- BEAT:
  - mem_addr = base + k, computed mod 2^ADDR_W.
  - Store: mem_write=1, mem_wdata = wdata[8k+7:8k].
  - Load: mem_read=1; at the clock edge, capture mem_rdata into lane k.
  - k increments every cycle. When k=N-1, go to RESP.
- RESP:
  - resp_valid=1 for exactly one cycle, then IDLE.
  - Load results: LB/LH are sign-extended from bit 7/15; LBU/LHU are zero-extended; LW is passed unchanged.
  - Unused upper lanes of the assembly register are ignored.
- No backpressure on the response. A req_valid arriving while busy is ignored (req_ready=0); the core must hold it.
- mem_read and mem_write are never high together. Both are 0 outside BEAT.

## Timing
- Reset values (asynchronous, immediate):
  - state=IDLE, req_ready=1.
  - resp_valid=0, resp_rdata=0, resp_err=0.
  - mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0.
- Request handshake at cycle 0. Beats occupy cycles 1..N. resp_valid is high in cycle N+1. req_ready returns in cycle N+2.
- Throughput: one access every N+2 cycles.
- Error path: resp_valid in cycle 1, req_ready in cycle 2.
- All memory-side outputs are registered or decoded from registered state only. No combinational path from req_* to mem_*.
- Reset asserted mid-BEAT: strobes drop immediately. Bytes already written remain. No response is generated.

## Structure
- Package riscv_lsu_pkg holds:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - the state enum (IDLE, BEAT, RESP);
  - a function size_from_funct3.
- Sub-module lsu_load_ext: combinational extension of the 32-bit assembly register by funct3. Also reused by the core's forwarding logic.

## Test plan
- SW 0xDEADBEEF at 0x10 → mem_write cycles 1–4 with addr 0x10..0x13 and data EF, BE, AD, DE; resp_valid at cycle 5 with err=0 and rdata=0.
- LW 0x10 after the above → four mem_read beats; resp_rdata=0xDEADBEEF at cycle 5.
- LB 0x13 → 0xFFFFFFDE. LBU 0x13 → 0x000000DE. LH 0x12 → 0xFFFFDEAD. LHU 0x12 → 0x0000DEAD. Each responds at cycle N+1.
- LH 0x11, SW 0x12 and funct3=011 → resp_err=1 at cycle 1; no mem_read or mem_write pulse; rdata=0.
- req_valid held during a busy SW → only one response. The held request is accepted in the cycle req_ready rises.
- rst_n low during beat 2 of SW 0x11223344 at 0x20 → strobes drop that cycle; 0x20 and 0x21 hold 44 and 33; 0x22 and 0x23 are unchanged; no resp_valid; req_ready=1 after rst_n rises.
